// File: rtl/sc_hdlc_stream_bridge.sv
// HDLC codec byte interface <-> AXI-Stream bridge: RX framing with status/length trailer, TX start/request handshake.
// Define SC_HDLC_BRIDGE_STATS_EN to add the stat_clr input and saturating frame/drop/error counters.
module sc_hdlc_stream_bridge #(
    parameter int ID_W      = 5,
    parameter int DEST_W    = 5,
    parameter int LEN_BYTES = 4,
    parameter int MAX_LEN   = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DEST_W-1:0] tdest,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tkeep,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [DEST_W-1:0] m_axis_tdest,
    output logic              m_axis_tuser,
    input  logic              tx_input_req,
    input  logic              tx_busy,
    input  logic              tx_flag,
    output logic              tx_start,
    output logic              tx_empty,
    output logic [7:0]        tx_data,
    output logic              tx_underrun,
    input  logic              rx_start,
    input  logic              rx_end,
    input  logic              rx_abort,
    input  logic              rx_error,
    input  logic              rx_dvalid,
    input  logic [7:0]        rx_data,
    output logic [31:0]       pkt_length,
    output logic              pkt_length_push,
    input  logic              data_afull,
    input  logic              pkt_afull
`ifdef SC_HDLC_BRIDGE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_drops,
    output logic [15:0]       stat_errors
`endif
);

    typedef enum logic [1:0] {RX_IDLE, RX_ACTIVE, RX_TRAILER, RX_DISCARD} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    localparam logic [2:0]  LAST_BEAT = 3'(LEN_BYTES);
    localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);

    rx_state_t   rx_state;
    tx_state_t   tx_state;
    logic [31:0] len;
    logic        trunc, lost, abort_q, end_q, err_q;
    logic        discard_next;
    logic [2:0]  bidx;
    logic        m_hs, out_free;
    logic [7:0]  status;
    logic [32:0] len_sum;
    logic [31:0] l_val;
    logic [1:0]  byte_sel;
    logic [7:0]  len_byte;
    logic [7:0]  trailer_beat;

    assign m_hs     = m_axis_tvalid & m_axis_tready;
    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign m_axis_tkeep = m_axis_tvalid;
    assign status   = {3'b000, trunc, lost, abort_q, end_q, err_q | lost};

    // Trailer length counts data plus status byte plus length field, saturating at 2^32-1.
    assign len_sum  = {1'b0, len} + 33'(1 + LEN_BYTES);
    assign l_val    = len_sum[32] ? 32'hFFFF_FFFF : len_sum[31:0];
    assign byte_sel = 2'(LAST_BEAT - bidx);

    // NOTE: every variable written in always_comb gets a default first, or a latch is inferred.
    always_comb begin
        len_byte = 8'h00;
        case (byte_sel)
            2'd0: len_byte = l_val[7:0];
            2'd1: len_byte = l_val[15:8];
            2'd2: len_byte = l_val[23:16];
            2'd3: len_byte = l_val[31:24];
            default: len_byte = 8'h00;
        endcase
        trailer_beat = (bidx == 3'd0) ? status : len_byte;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state        <= RX_IDLE;
            m_axis_tdata    <= 8'h00;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            m_axis_tid      <= '0;
            m_axis_tdest    <= '0;
            len             <= '0;
            trunc           <= 1'b0;
            lost            <= 1'b0;
            abort_q         <= 1'b0;
            end_q           <= 1'b0;
            err_q           <= 1'b0;
            discard_next    <= 1'b0;
            bidx            <= '0;
            pkt_length      <= '0;
            pkt_length_push <= 1'b0;
        end else begin
            pkt_length_push <= 1'b0;
            if (m_hs)
                m_axis_tvalid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_start) begin
                        if (!data_afull && !pkt_afull) begin
                            rx_state     <= RX_ACTIVE;
                            m_axis_tdest <= tdest;
                            len          <= '0;
                            trunc        <= 1'b0;
                            lost         <= 1'b0;
                            abort_q      <= 1'b0;
                            end_q        <= 1'b0;
                            err_q        <= 1'b0;
                            discard_next <= 1'b0;
                            bidx         <= '0;
                        end else begin
                            rx_state <= RX_DISCARD;
                        end
                    end
                end
                RX_ACTIVE: begin
                    if (rx_dvalid) begin
                        if (out_free && len < MAX_LEN_W) begin
                            m_axis_tdata  <= rx_data;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tuser  <= 1'b0;
                            if (len != 32'hFFFF_FFFF)
                                len <= len + 32'd1;
                        end else if (len >= MAX_LEN_W) begin
                            trunc <= 1'b1;
                        end else begin
                            lost <= 1'b1;
                        end
                    end
                    // A new start mid-frame closes this frame as aborted and drops the newcomer.
                    if (rx_start) begin
                        abort_q      <= 1'b1;
                        end_q        <= 1'b0;
                        err_q        <= rx_error;
                        discard_next <= 1'b1;
                        rx_state     <= RX_TRAILER;
                    end else if (rx_end || rx_abort) begin
                        abort_q  <= rx_abort;
                        end_q    <= rx_end;
                        err_q    <= rx_error;
                        rx_state <= RX_TRAILER;
                    end
                end
                RX_TRAILER: begin
                    if (rx_start)
                        discard_next <= 1'b1;
                    else if (rx_end || rx_abort)
                        discard_next <= 1'b0;
                    if (out_free && bidx <= LAST_BEAT) begin
                        m_axis_tdata  <= trailer_beat;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (bidx == LAST_BEAT);
                        m_axis_tuser  <= (bidx == LAST_BEAT) & status[0];
                        bidx          <= bidx + 3'd1;
                    end
                    if (m_hs && m_axis_tlast) begin
                        m_axis_tlast    <= 1'b0;
                        m_axis_tuser    <= 1'b0;
                        pkt_length      <= l_val;
                        pkt_length_push <= 1'b1;
                        m_axis_tid      <= m_axis_tid + 1'b1;
                        rx_state        <= discard_next ? RX_DISCARD : RX_IDLE;
                    end
                end
                RX_DISCARD: begin
                    if (rx_end || rx_abort)
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign s_axis_tready = (tx_state == TX_SEND) & tx_input_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state    <= TX_IDLE;
            tx_start    <= 1'b0;
            tx_empty    <= 1'b1;
            tx_data     <= 8'h00;
            tx_underrun <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            tx_underrun <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_flag && s_axis_tvalid && !tx_busy) begin
                        tx_start <= 1'b1;
                        tx_empty <= 1'b0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_input_req) begin
                        if (s_axis_tvalid) begin
                            tx_data <= s_axis_tdata;
                            if (s_axis_tlast) begin
                                tx_empty <= 1'b1;
                                tx_state <= TX_IDLE;
                            end
                        end else begin
                            tx_underrun <= 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef SC_HDLC_BRIDGE_STATS_EN
    logic drop_evt, frame_evt;

    // A dropped frame is any start that will not be forwarded.
    assign drop_evt  = rx_start & (((rx_state == RX_IDLE) & (data_afull | pkt_afull)) |
                                   (rx_state == RX_ACTIVE) | (rx_state == RX_TRAILER));
    assign frame_evt = (rx_state == RX_TRAILER) & m_hs & m_axis_tlast;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_frames <= '0;
            stat_drops  <= '0;
            stat_errors <= '0;
        end else if (stat_clr) begin
            stat_frames <= '0;
            stat_drops  <= '0;
            stat_errors <= '0;
        end else begin
            if (frame_evt && stat_frames != 16'hFFFF)
                stat_frames <= stat_frames + 16'd1;
            if (frame_evt && m_axis_tuser && stat_errors != 16'hFFFF)
                stat_errors <= stat_errors + 16'd1;
            if (drop_evt && stat_drops != 16'hFFFF)
                stat_drops <= stat_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sc_hdlc_stream_bridge.sv
// Self-checking bench for sc_hdlc_stream_bridge: table-driven RX frames against a beat/length scoreboard,
// plus hand sequences for lost bytes, discard, mid-frame reset and the TX handshake.
module tb_sc_hdlc_stream_bridge;

    localparam int ID_W      = 5;
    localparam int DEST_W    = 5;
    localparam int LEN_BYTES = 4;
    localparam int MAX_LEN   = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [DEST_W-1:0] tdest = '0;
    logic [7:0]        s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic              m_axis_tkeep;
    logic [ID_W-1:0]   m_axis_tid;
    logic [DEST_W-1:0] m_axis_tdest;
    logic              m_axis_tuser;
    logic              tx_input_req = 1'b0, tx_busy = 1'b0, tx_flag = 1'b0;
    logic              tx_start, tx_empty, tx_underrun;
    logic [7:0]        tx_data;
    logic              rx_start = 1'b0, rx_end = 1'b0, rx_abort = 1'b0, rx_error = 1'b0, rx_dvalid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic [31:0]       pkt_length;
    logic              pkt_length_push;
    logic              data_afull = 1'b0, pkt_afull = 1'b0;
`ifdef SC_HDLC_BRIDGE_STATS_EN
    logic              stat_clr = 1'b0;
    logic [15:0]       stat_frames, stat_drops, stat_errors;
`endif

    sc_hdlc_stream_bridge #(
        .ID_W(ID_W), .DEST_W(DEST_W), .LEN_BYTES(LEN_BYTES), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rstn(rstn), .tdest(tdest),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .tx_input_req(tx_input_req), .tx_busy(tx_busy), .tx_flag(tx_flag),
        .tx_start(tx_start), .tx_empty(tx_empty), .tx_data(tx_data), .tx_underrun(tx_underrun),
        .rx_start(rx_start), .rx_end(rx_end), .rx_abort(rx_abort), .rx_error(rx_error),
        .rx_dvalid(rx_dvalid), .rx_data(rx_data),
        .pkt_length(pkt_length), .pkt_length_push(pkt_length_push),
        .data_afull(data_afull), .pkt_afull(pkt_afull)
`ifdef SC_HDLC_BRIDGE_STATS_EN
        , .stat_clr(stat_clr), .stat_frames(stat_frames), .stat_drops(stat_drops), .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        data;
        logic              last;
        logic              user;
        logic [ID_W-1:0]   tid;
        logic [DEST_W-1:0] dest;
    } beat_t;

    typedef struct {
        logic [5:0][7:0]   data;
        int                n;
        bit                abort;
        bit                err;
        bit                toggle;
        logic [7:0]        status;
        logic [31:0]       plen;
        bit                user;
        logic [DEST_W-1:0] dest;
    } rx_vec_t;

    beat_t       exp_q[$];
    logic [31:0] len_q[$];
    beat_t       cur;
    rx_vec_t     vecs[5];
    logic [ID_W-1:0] exp_tid = '0;
    int          checks = 0;
    int          failures = 0;
    int          tready_mode = 0;   // 0 low, 1 high, 2 toggle
    int          tx_start_cnt = 0;
    int          underrun_cnt = 0;
    bit          push_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ~m_axis_tready;
            endcase
        end
    end

    // Scoreboard side: beats and lengths are compared as the DUT hands them over.
    always @(negedge clk) begin
        if (push_pending)
            check("push_latency", {31'b0, pkt_length_push}, 32'd1);
        push_pending = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_beat_unexpected actual=0x%0h expected=none", m_axis_tdata);
            end else begin
                cur = exp_q.pop_front();
                check("rx_beat", {21'b0, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                      {21'b0, 1'b1, cur.last, cur.user, cur.data});
                check("rx_tid_dest", {22'b0, m_axis_tid, m_axis_tdest}, {22'b0, cur.tid, cur.dest});
            end
        end
        if (pkt_length_push) begin
            if (len_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pkt_push_unexpected actual=0x%0h expected=none", pkt_length);
            end else begin
                check("pkt_length", pkt_length, len_q.pop_front());
            end
        end
        if (tx_start)    tx_start_cnt++;
        if (tx_underrun) underrun_cnt++;
    end

    task automatic expect_rx(input rx_vec_t v);
        logic [31:0] pl;
        pl = v.plen;
        for (int i = 0; i < v.n && i < MAX_LEN; i++)
            exp_q.push_back('{data: v.data[i], last: 1'b0, user: 1'b0, tid: exp_tid, dest: v.dest});
        exp_q.push_back('{data: v.status, last: 1'b0, user: 1'b0, tid: exp_tid, dest: v.dest});
        for (int b = LEN_BYTES - 1; b >= 0; b--)
            exp_q.push_back('{data: pl[8*b +: 8], last: (b == 0), user: (b == 0) && v.user,
                              tid: exp_tid, dest: v.dest});
        len_q.push_back(v.plen);
        exp_tid = exp_tid + 1'b1;
    endtask

    // Bytes are spaced one idle cycle apart so a 50% tready pattern never overruns the output register.
    task automatic drive_rx(input rx_vec_t v);
        tdest    = v.dest;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            rx_dvalid = 1'b1;
            rx_data   = v.data[i];
            tick();
            rx_dvalid = 1'b0;
            tick();
        end
        rx_end   = !v.abort;
        rx_abort = v.abort;
        rx_error = v.err;
        tick();
        rx_end   = 1'b0;
        rx_abort = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (k < 300 && (exp_q.size() != 0 || len_q.size() != 0)) begin
            tick();
            k++;
        end
        check({name, "_drained"}, 32'(exp_q.size() + len_q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: {8'h00, 8'h00, 8'h00, 8'h33, 8'h22, 8'h11}, n: 3, abort: 0, err: 0, toggle: 0,
                    status: 8'h02, plen: 32'd8, user: 0, dest: 5'h03};
        vecs[1] = '{data: {8'h00, 8'h00, 8'h00, 8'h33, 8'h22, 8'h11}, n: 3, abort: 0, err: 0, toggle: 1,
                    status: 8'h02, plen: 32'd8, user: 0, dest: 5'h07};
        vecs[2] = '{data: {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, n: 6, abort: 1, err: 0, toggle: 0,
                    status: 8'h14, plen: 32'd9, user: 0, dest: 5'h1F};
        vecs[3] = '{data: {8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h44}, n: 2, abort: 0, err: 1, toggle: 1,
                    status: 8'h03, plen: 32'd7, user: 1, dest: 5'h0A};
        vecs[4] = '{data: {8'h00, 8'h00, 8'h84, 8'h83, 8'h82, 8'h81}, n: 4, abort: 0, err: 0, toggle: 0,
                    status: 8'h02, plen: 32'd9, user: 0, dest: 5'h12};

        tick();
        tick();
        check("reset_m_axis", {16'b0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata},
              32'd0);
        check("reset_tid_tdest", {22'b0, m_axis_tid, m_axis_tdest}, 32'd0);
        check("reset_tx", {21'b0, tx_start, tx_empty, tx_underrun, tx_data}, {21'b0, 3'b010, 8'h00});
        check("reset_pkt", {31'b0, pkt_length_push} | pkt_length, 32'd0);
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            tready_mode = vecs[v].toggle ? 2 : 1;
            expect_rx(vecs[v]);
            drive_rx(vecs[v]);
            wait_drain($sformatf("rx_vec%0d", v));
            if (v == 1) begin
                // Almost-full at frame start: the whole frame is dropped, the next one is normal.
                data_afull = 1'b1;
                drive_rx(vecs[0]);
                data_afull = 1'b0;
                wait_drain("rx_discard");
`ifdef SC_HDLC_BRIDGE_STATS_EN
                check("stat_drops", {16'b0, stat_drops}, 32'd1);
`endif
            end
        end

        // Output held while tready is low: the second byte is lost, status 0x0D on abort.
        tready_mode = 0;
        tick();
        exp_q.push_back('{data: 8'hAA, last: 1'b0, user: 1'b0, tid: exp_tid, dest: 5'h05});
        exp_q.push_back('{data: 8'h0D, last: 1'b0, user: 1'b0, tid: exp_tid, dest: 5'h05});
        exp_q.push_back('{data: 8'h00, last: 1'b0, user: 1'b0, tid: exp_tid, dest: 5'h05});
        exp_q.push_back('{data: 8'h00, last: 1'b0, user: 1'b0, tid: exp_tid, dest: 5'h05});
        exp_q.push_back('{data: 8'h00, last: 1'b0, user: 1'b0, tid: exp_tid, dest: 5'h05});
        exp_q.push_back('{data: 8'h06, last: 1'b1, user: 1'b1, tid: exp_tid, dest: 5'h05});
        len_q.push_back(32'd6);
        exp_tid = exp_tid + 1'b1;
        tdest    = 5'h05;
        rx_start = 1'b1;
        tick();
        rx_start  = 1'b0;
        rx_dvalid = 1'b1;
        rx_data   = 8'hAA;
        tick();
        check("rx_dvalid_latency", {23'b0, m_axis_tvalid, m_axis_tdata}, {23'b0, 1'b1, 8'hAA});
        rx_data = 8'hBB;
        tick();
        check("rx_hold_stable", {23'b0, m_axis_tvalid, m_axis_tdata}, {23'b0, 1'b1, 8'hAA});
        rx_dvalid = 1'b0;
        rx_abort  = 1'b1;
        tick();
        rx_abort    = 1'b0;
        tready_mode = 1;
        wait_drain("rx_lost");

`ifdef SC_HDLC_BRIDGE_STATS_EN
        check("stat_frames", {16'b0, stat_frames}, 32'd6);
        check("stat_errors", {16'b0, stat_errors}, 32'd2);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_clr", {stat_frames, stat_drops} | {16'b0, stat_errors}, 32'd0);
`endif

        // Reset in the middle of a frame: nothing more comes out, counters restart.
        tready_mode = 0;
        tick();
        rx_start = 1'b1;
        tick();
        rx_start  = 1'b0;
        rx_dvalid = 1'b1;
        rx_data   = 8'h77;
        tick();
        rx_dvalid = 1'b0;
        check("midframe_loaded", {31'b0, m_axis_tvalid}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midframe_reset", {25'b0, m_axis_tvalid, pkt_length_push, m_axis_tid}, 32'd0);
        tick();
        rstn        = 1'b1;
        exp_tid     = '0;
        tready_mode = 1;
        rx_end      = 1'b1;
        tick();
        rx_end = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midframe_no_push", pkt_length, 32'd0);

        // TX: busy blocks the start, then a 2-byte packet.
        tx_busy       = 1'b1;
        tx_flag       = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hA5;
        tick();
        tick();
        check("tx_busy_block", {30'b0, tx_empty, tx_start}, {30'b0, 2'b10});
        tx_busy = 1'b0;
        tick();
        check("tx_start_pulse", {30'b0, tx_start, tx_empty}, {30'b0, 2'b10});
        tx_flag = 1'b0;
        tick();
        check("tx_start_one_cycle", {30'b0, tx_start, s_axis_tready}, 32'd0);
        tx_input_req = 1'b1;
        #1;
        check("tx_tready_follows_req", {31'b0, s_axis_tready}, 32'd1);
        tick();
        check("tx_data_a5", {23'b0, tx_empty, tx_data}, {23'b0, 1'b0, 8'hA5});
        s_axis_tdata = 8'h5A;
        s_axis_tlast = 1'b1;
        tick();
        check("tx_data_5a", {22'b0, s_axis_tready, tx_empty, tx_data}, {22'b0, 2'b01, 8'h5A});
        tx_input_req  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tick();
        check("tx_start_count", 32'(tx_start_cnt), 32'd1);

        // TX underrun: request with no data, then the frame completes.
        tx_flag       = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h3C;
        s_axis_tlast  = 1'b1;
        tick();
        tx_flag       = 1'b0;
        s_axis_tvalid = 1'b0;
        tx_input_req  = 1'b1;
        tick();
        check("tx_underrun_pulse", {30'b0, tx_underrun, tx_empty}, {30'b0, 2'b10});
        tx_input_req = 1'b0;
        tick();
        check("tx_underrun_clear", {31'b0, tx_underrun}, 32'd0);
        s_axis_tvalid = 1'b1;
        tx_input_req  = 1'b1;
        tick();
        check("tx_after_underrun", {23'b0, tx_empty, tx_data}, {23'b0, 1'b1, 8'h3C});
        tx_input_req  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tick();
        tick();
        check("tx_counts", {tx_start_cnt[15:0], underrun_cnt[15:0]}, {16'd2, 16'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
